// File: rtl/im2col_spc_core.sv
// im2col_spc_core: register-programmed im2col controller that drives one DMA channel per output row segment.
module im2col_spc_core #(
    parameter int          DMA_CH_NUM  = 1,
    parameter int          DMA_CH      = 0,
    parameter logic [31:0] DMA_BASE    = 32'h2003_0000,
    parameter logic [31:0] SRC_OFF     = 32'h00,
    parameter logic [31:0] DST_OFF     = 32'h04,
    parameter logic [31:0] SIZE_OFF    = 32'h0C,
    parameter logic [31:0] SRC_INC_OFF = 32'h14,
    parameter logic [31:0] DST_INC_OFF = 32'h18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_req_valid_i,
    input  logic                  reg_req_write_i,
    input  logic [31:0]           reg_req_addr_i,
    input  logic [31:0]           reg_req_wdata_i,
    input  logic [3:0]            reg_req_wstrb_i,
    output logic [31:0]           reg_rsp_rdata_o,
    output logic                  reg_rsp_error_o,
    output logic                  reg_rsp_ready_o,
    output logic                  aopb_req_valid_o,
    output logic                  aopb_req_write_o,
    output logic [31:0]           aopb_req_addr_o,
    output logic [31:0]           aopb_req_wdata_o,
    output logic [3:0]            aopb_req_wstrb_o,
    input  logic [31:0]           aopb_rsp_rdata_i,
    input  logic                  aopb_rsp_error_i,
    input  logic                  aopb_rsp_ready_i,
    input  logic [DMA_CH_NUM-1:0] dma_done_i,
    output logic                  done_int_o
);
    typedef enum logic [3:0] {
        IDLE, WR_SRC, WR_DST, WR_SINC, WR_DINC, WR_SIZE, WAIT_LOW, WAIT_HIGH, FINISH
    } state_t;

    state_t      r_state;
    logic        r_int_en, r_busy, r_done, r_err, r_int, r_valid;
    logic [31:0] r_src_ptr, r_dst_ptr, r_addr, r_wdata;
    logic [15:0] r_iw, r_ih, r_ow, r_oh, r_y;
    logic [7:0]  r_fw, r_fh, r_s, r_fx, r_fy;
    logic [31:0] r_src_fy, r_src_fx, r_src_cur, r_dst_cur;

    logic [7:0]  w_off;
    logic        w_map, w_wr, w_cfg_wr, w_start, w_int_en_nx, w_empty;
    logic        w_last_y, w_last_fx, w_last_fy;
    logic [31:0] w_raw, w_bmask, w_wm, w_w1c, w_maddr, w_mdata;
    logic [31:0] w_ystep, w_rowstep, w_dstep;
    logic [23:0] w_siw;
    state_t      w_wr_next;
    logic        w_unused;

    assign w_off       = reg_req_addr_i[7:0];
    assign w_map       = (w_off[1:0] == 2'b00) && (w_off <= 8'h18);
    assign w_wr        = reg_req_valid_i && reg_req_write_i && w_map;
    assign w_cfg_wr    = w_wr && !r_busy;
    assign w_raw       = (w_off == 8'h00) ? {30'b0, r_int_en, 1'b0} :
                         (w_off == 8'h04) ? {29'b0, r_err, r_done, r_busy} :
                         (w_off == 8'h08) ? r_src_ptr :
                         (w_off == 8'h0C) ? r_dst_ptr :
                         (w_off == 8'h10) ? {r_ih, r_iw} :
                         (w_off == 8'h14) ? {8'b0, r_s, r_fh, r_fw} :
                         (w_off == 8'h18) ? {r_oh, r_ow} : 32'b0;
    assign w_bmask     = {{8{reg_req_wstrb_i[3]}}, {8{reg_req_wstrb_i[2]}},
                          {8{reg_req_wstrb_i[1]}}, {8{reg_req_wstrb_i[0]}}};
    assign w_wm        = (w_raw & ~w_bmask) | (reg_req_wdata_i & w_bmask);
    assign w_w1c       = reg_req_wdata_i & w_bmask;
    assign w_start     = w_cfg_wr && (w_off == 8'h00) && w_wm[0];
    // a CTRL write that sets START and INT_EN together must already arm the interrupt
    assign w_int_en_nx = (w_wr && w_off == 8'h00) ? w_wm[1] : r_int_en;
    assign w_empty     = (r_fh == 8'd0) || (r_fw == 8'd0) || (r_oh == 16'd0) || (r_ow == 16'd0);

    assign reg_rsp_ready_o = reg_req_valid_i;
    assign reg_rsp_error_o = reg_req_valid_i && !w_map;
    assign reg_rsp_rdata_o = (reg_req_valid_i && w_map) ? w_raw : 32'b0;

    assign w_siw     = {16'b0, r_s} * {8'b0, r_iw};
    assign w_ystep   = {6'b0, w_siw, 2'b0};
    assign w_rowstep = {14'b0, r_iw, 2'b0};
    assign w_dstep   = {14'b0, r_ow, 2'b0};
    assign w_last_y  = r_y == r_oh - 16'd1;
    assign w_last_fx = r_fx == r_fw - 8'd1;
    assign w_last_fy = r_fy == r_fh - 8'd1;

    assign w_maddr   = DMA_BASE + ((r_state == WR_SRC)  ? SRC_OFF :
                                   (r_state == WR_DST)  ? DST_OFF :
                                   (r_state == WR_SINC) ? SRC_INC_OFF :
                                   (r_state == WR_DINC) ? DST_INC_OFF : SIZE_OFF);
    assign w_mdata   = (r_state == WR_SRC)  ? r_src_cur :
                       (r_state == WR_DST)  ? r_dst_cur :
                       (r_state == WR_SINC) ? {22'b0, r_s, 2'b0} :
                       (r_state == WR_DINC) ? 32'd4 : w_dstep;
    assign w_wr_next = (r_state == WR_SRC)  ? WR_DST :
                       (r_state == WR_DST)  ? WR_SINC :
                       (r_state == WR_SINC) ? WR_DINC :
                       (r_state == WR_DINC) ? WR_SIZE : WAIT_LOW;

    assign aopb_req_valid_o = r_valid;
    assign aopb_req_write_o = r_valid;
    assign aopb_req_wstrb_o = {4{r_valid}};
    assign aopb_req_addr_o  = r_addr;
    assign aopb_req_wdata_o = r_wdata;
    assign done_int_o       = r_int;
    assign w_unused         = ^{aopb_rsp_rdata_i, reg_req_addr_i[31:8]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_int_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_int     <= 1'b0;
            r_valid   <= 1'b0;
            r_addr    <= 32'b0;
            r_wdata   <= 32'b0;
            r_src_ptr <= 32'b0;
            r_dst_ptr <= 32'b0;
            r_iw      <= 16'b0;
            r_ih      <= 16'b0;
            r_ow      <= 16'b0;
            r_oh      <= 16'b0;
            r_fw      <= 8'b0;
            r_fh      <= 8'b0;
            r_s       <= 8'b0;
            r_y       <= 16'b0;
            r_fx      <= 8'b0;
            r_fy      <= 8'b0;
            r_src_fy  <= 32'b0;
            r_src_fx  <= 32'b0;
            r_src_cur <= 32'b0;
            r_dst_cur <= 32'b0;
        end else begin
            r_int <= 1'b0;
            if (w_wr && w_off == 8'h00) r_int_en <= w_wm[1];
            if (w_wr && w_off == 8'h04) begin
                r_done <= r_done & ~w_w1c[1];
                r_err  <= r_err & ~w_w1c[2];
            end
            if (w_cfg_wr && w_off == 8'h08) r_src_ptr <= w_wm;
            if (w_cfg_wr && w_off == 8'h0C) r_dst_ptr <= w_wm;
            if (w_cfg_wr && w_off == 8'h10) {r_ih, r_iw} <= w_wm;
            if (w_cfg_wr && w_off == 8'h14) {r_s, r_fh, r_fw} <= w_wm[23:0];
            if (w_cfg_wr && w_off == 8'h18) {r_oh, r_ow} <= w_wm;
            // FSM updates come last so a FINISH set of DONE beats a coincident clear
            case (r_state)
                IDLE: if (w_start) begin
                    r_busy    <= 1'b1;
                    r_y       <= 16'd0;
                    r_fx      <= 8'd0;
                    r_fy      <= 8'd0;
                    r_src_fy  <= r_src_ptr;
                    r_src_fx  <= r_src_ptr;
                    r_src_cur <= r_src_ptr;
                    r_dst_cur <= r_dst_ptr;
                    r_state   <= w_empty ? FINISH : WR_SRC;
                    r_int     <= w_empty && w_int_en_nx;
                end
                WR_SRC, WR_DST, WR_SINC, WR_DINC, WR_SIZE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_addr  <= w_maddr;
                        r_wdata <= w_mdata;
                    end else if (aopb_rsp_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= aopb_rsp_error_i ? FINISH : w_wr_next;
                        r_err   <= r_err | aopb_rsp_error_i;
                        r_int   <= aopb_rsp_error_i && w_int_en_nx;
                    end
                end
                WAIT_LOW: if (!dma_done_i[DMA_CH]) r_state <= WAIT_HIGH;
                WAIT_HIGH: if (dma_done_i[DMA_CH]) begin
                    r_dst_cur <= r_dst_cur + w_dstep;
                    r_state   <= WR_SRC;
                    if (!w_last_y) begin
                        r_y       <= r_y + 16'd1;
                        r_src_cur <= r_src_cur + w_ystep;
                    end else if (!w_last_fx) begin
                        r_y       <= 16'd0;
                        r_fx      <= r_fx + 8'd1;
                        r_src_fx  <= r_src_fx + 32'd4;
                        r_src_cur <= r_src_fx + 32'd4;
                    end else if (!w_last_fy) begin
                        r_y       <= 16'd0;
                        r_fx      <= 8'd0;
                        r_fy      <= r_fy + 8'd1;
                        r_src_fy  <= r_src_fy + w_rowstep;
                        r_src_fx  <= r_src_fy + w_rowstep;
                        r_src_cur <= r_src_fy + w_rowstep;
                    end else begin
                        r_state <= FINISH;
                        r_int   <= w_int_en_nx;
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im2col_spc_core.sv
// tb_im2col_spc_core: scoreboard bench with a DMA/bus responder model for im2col_spc_core.
module tb_im2col_spc_core;
    localparam logic [31:0] BASE = 32'h2003_0000;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        reg_req_valid_i = 1'b0, reg_req_write_i = 1'b0;
    logic [31:0] reg_req_addr_i = 32'b0, reg_req_wdata_i = 32'b0;
    logic [3:0]  reg_req_wstrb_i = 4'b0;
    logic [31:0] reg_rsp_rdata_o;
    logic        reg_rsp_error_o, reg_rsp_ready_o;
    logic        aopb_req_valid_o, aopb_req_write_o;
    logic [31:0] aopb_req_addr_o, aopb_req_wdata_o;
    logic [3:0]  aopb_req_wstrb_o;
    logic [31:0] aopb_rsp_rdata_i;
    logic        aopb_rsp_error_i, aopb_rsp_ready_i;
    logic [0:0]  dma_done_i;
    logic        done_int_o;

    int          n_cmp = 0, n_bad = 0, n_wr = 0, n_int = 0;
    int          bp_cycles = 0, hold = 0, dma_cnt = 0;
    logic        err_once = 1'b0, last_ready;
    logic [31:0] hold_addr, hold_data;
    logic [63:0] q[$];

    always #5 clk_i = ~clk_i;

    im2col_spc_core dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_req_valid_i(reg_req_valid_i), .reg_req_write_i(reg_req_write_i),
        .reg_req_addr_i(reg_req_addr_i), .reg_req_wdata_i(reg_req_wdata_i),
        .reg_req_wstrb_i(reg_req_wstrb_i), .reg_rsp_rdata_o(reg_rsp_rdata_o),
        .reg_rsp_error_o(reg_rsp_error_o), .reg_rsp_ready_o(reg_rsp_ready_o),
        .aopb_req_valid_o(aopb_req_valid_o), .aopb_req_write_o(aopb_req_write_o),
        .aopb_req_addr_o(aopb_req_addr_o), .aopb_req_wdata_o(aopb_req_wdata_o),
        .aopb_req_wstrb_o(aopb_req_wstrb_o), .aopb_rsp_rdata_i(aopb_rsp_rdata_i),
        .aopb_rsp_error_i(aopb_rsp_error_i), .aopb_rsp_ready_i(aopb_rsp_ready_i),
        .dma_done_i(dma_done_i), .done_int_o(done_int_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b1;
        reg_req_addr_i  = {24'b0, a};
        reg_req_wdata_i = d;
        reg_req_wstrb_i = s;
        @(posedge clk_i);
        #1 reg_req_valid_i = 1'b0;
        reg_req_write_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b0;
        reg_req_addr_i  = {24'b0, a};
        #1 d = reg_rsp_rdata_o;
        e = reg_rsp_error_o;
        last_ready = reg_rsp_ready_o;
        @(posedge clk_i);
        #1 reg_req_valid_i = 1'b0;
    endtask

    // reference addresses come straight from the closed-form im2col formulas
    task automatic push_job(input int iw, input int fw, input int fh, input int s,
                            input int ow, input int oh);
        logic [31:0] a, d;
        if (fw == 0 || fh == 0 || ow == 0 || oh == 0) return;
        for (int fy = 0; fy < fh; fy++)
            for (int fx = 0; fx < fw; fx++)
                for (int y = 0; y < oh; y++) begin
                    a = 32'h1000 + 32'(4 * ((y * s + fy) * iw + fx));
                    d = 32'h2000 + 32'(4 * (((fy * fw + fx) * oh + y) * ow));
                    q.push_back({BASE + 32'h00, a});
                    q.push_back({BASE + 32'h04, d});
                    q.push_back({BASE + 32'h14, 32'(4 * s)});
                    q.push_back({BASE + 32'h18, 32'd4});
                    q.push_back({BASE + 32'h0C, 32'(4 * ow)});
                end
    endtask

    task automatic cfg_push(input int iw, input int ih, input int fw, input int fh,
                            input int s, input int ow, input int oh);
        reg_wr(8'h08, 32'h1000, 4'hF);
        reg_wr(8'h0C, 32'h2000, 4'hF);
        reg_wr(8'h10, {16'(ih), 16'(iw)}, 4'hF);
        reg_wr(8'h14, {8'b0, 8'(s), 8'(fh), 8'(fw)}, 4'hF);
        reg_wr(8'h18, {16'(oh), 16'(ow)}, 4'hF);
        n_wr = 0;
        n_int = 0;
        q.delete();
        push_job(iw, fw, fh, s, ow, oh);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        logic e;
        int n = 0;
        do begin
            reg_rd(8'h04, d, e);
            n++;
        end while (d[0] && n < 5000);
        if (d[0]) chk({tag, "_idle_timeout"}, d, 32'h2);
    endtask

    task automatic finish_chk(input string tag, input int exp_wr, input logic [31:0] exp_st);
        logic [31:0] d;
        logic e;
        wait_idle(tag);
        chk({tag, "_writes"}, n_wr, exp_wr);
        chk({tag, "_int_pulses"}, n_int, 1);
        chk({tag, "_sb_left"}, q.size(), 0);
        reg_rd(8'h04, d, e);
        chk({tag, "_status"}, d, exp_st);
        reg_wr(8'h04, 32'h6, 4'hF);
        reg_rd(8'h04, d, e);
        chk({tag, "_status_clr"}, d, 32'h0);
    endtask

    // bus slave + DMA model: drives responses on the falling edge, checks every accepted write
    initial begin
        logic [63:0] e;
        aopb_rsp_ready_i = 1'b0;
        aopb_rsp_error_i = 1'b0;
        aopb_rsp_rdata_i = 32'b0;
        dma_done_i = 1'b1;
        forever begin
            @(negedge clk_i);
            aopb_rsp_ready_i = 1'b0;
            aopb_rsp_error_i = 1'b0;
            if (!rst_i) begin
                if (done_int_o) begin
                    n_int++;
                    chk("int_after_last_write", q.size(), 0);
                end
                if (dma_cnt > 0) begin
                    dma_cnt--;
                    dma_done_i = (dma_cnt == 0);
                end
                if (aopb_req_valid_o) begin
                    if (hold == 0) begin
                        hold_addr = aopb_req_addr_o;
                        hold_data = aopb_req_wdata_o;
                    end else begin
                        chk("bp_addr_stable", aopb_req_addr_o, hold_addr);
                        chk("bp_data_stable", aopb_req_wdata_o, hold_data);
                    end
                    if (hold < bp_cycles) hold++;
                    else begin
                        hold = 0;
                        aopb_rsp_ready_i = 1'b1;
                        n_wr++;
                        e = (q.size() > 0) ? q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                        chk("wr_addr", aopb_req_addr_o, e[63:32]);
                        chk("wr_data", aopb_req_wdata_o, e[31:0]);
                        chk("wr_attr", {27'b0, aopb_req_write_o, aopb_req_wstrb_o}, 32'h1F);
                        if (err_once) begin
                            aopb_rsp_error_i = 1'b1;
                            err_once = 1'b0;
                        end
                        if (aopb_req_addr_o == BASE + 32'h0C) dma_cnt = 4;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic e;
        int n;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b0;
        chk("rst_valid", aopb_req_valid_o, 0);
        chk("rst_int", done_int_o, 0);
        reg_rd(8'h00, d, e); chk("rst_ctrl", d, 0);
        reg_rd(8'h04, d, e); chk("rst_status", d, 0);
        reg_rd(8'h18, d, e); chk("rst_ow_oh", d, 0);

        reg_wr(8'h08, 32'h1000, 4'hF);
        reg_rd(8'h08, d, e); chk("src_readback", d, 32'h1000);
        reg_rd(8'h40, d, e);
        chk("unmapped_err", e, 1);
        chk("unmapped_rdata", d, 0);
        chk("unmapped_ready", last_ready, 1);
        reg_wr(8'h0C, 32'hAABB_CCDD, 4'b0001);
        reg_rd(8'h0C, d, e); chk("wstrb_lane0", d, 32'h0000_00DD);

        cfg_push(4, 4, 2, 2, 1, 3, 3);
        reg_wr(8'h00, 32'h3, 4'hF);
        reg_rd(8'h00, d, e); chk("ctrl_start_selfclear", d, 32'h2);
        finish_chk("basic", 60, 32'h2);

        cfg_push(5, 5, 3, 3, 2, 2, 2);
        reg_wr(8'h00, 32'h3, 4'hF);
        finish_chk("stride2", 90, 32'h2);

        bp_cycles = 5;
        cfg_push(4, 4, 2, 2, 1, 3, 3);
        reg_wr(8'h00, 32'h3, 4'hF);
        repeat (3) @(negedge clk_i);
        reg_wr(8'h00, 32'h3, 4'hF);
        reg_wr(8'h08, 32'hDEAD_0000, 4'hF);
        finish_chk("backpressure", 60, 32'h2);
        reg_rd(8'h08, d, e); chk("busy_write_ignored", d, 32'h1000);
        bp_cycles = 0;

        cfg_push(4, 4, 2, 2, 1, 0, 3);
        reg_wr(8'h00, 32'h3, 4'hF);
        finish_chk("ow_zero", 0, 32'h2);

        cfg_push(4, 4, 2, 2, 1, 3, 3);
        q.delete();
        q.push_back({BASE, 32'h1000});
        err_once = 1'b1;
        reg_wr(8'h00, 32'h3, 4'hF);
        finish_chk("master_err", 1, 32'h6);

        cfg_push(4, 4, 2, 2, 1, 3, 3);
        reg_wr(8'h00, 32'h3, 4'hF);
        n = 0;
        while (dma_done_i[0] && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("reached_wait_high", dma_done_i, 0);
        @(negedge clk_i) rst_i = 1'b1;
        #1 chk("midrst_valid", aopb_req_valid_o, 0);
        dma_cnt = 0;
        dma_done_i = 1'b1;
        hold = 0;
        q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_int", done_int_o, 0);
        reg_rd(8'h04, d, e); chk("midrst_status", d, 0);
        reg_rd(8'h08, d, e); chk("midrst_src", d, 0);
        reg_rd(8'h10, d, e); chk("midrst_iw_ih", d, 0);
        cfg_push(4, 4, 2, 2, 1, 3, 3);
        reg_wr(8'h00, 32'h3, 4'hF);
        finish_chk("after_rst", 60, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
